// File: rtl/idct_pkg.sv
// Shared constants, FSM state type and transposed-address helper for the IDCT transpose controller.
package idct_pkg;

    localparam int DW  = 16;
    localparam int N   = 8;
    localparam int AW  = 6;
    localparam int BLK = N * N;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Row-major counter -> column-major RAM address: 0,8,..,56,1,9,..,63
    function automatic logic [AW-1:0] tr_addr(input logic [AW-1:0] cnt);
        return {cnt[2:0], cnt[5:3]};
    endfunction

endpackage

// File: rtl/idct_transpose_ctrl_if.sv
// Row-stage input, column-stage output and transpose-RAM port bundle.
// master = surrounding pipeline/RAM, slave = the controller.
interface idct_transpose_ctrl_if #(parameter int DW = idct_pkg::DW);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          ram_wr_rd;
    logic [DW-1:0] ram_data_in;
    logic [5:0]    ram_wr_addr;
    logic [5:0]    ram_rd_addr;
    logic [DW-1:0] ram_data_out;

    modport master (
        output in_valid, in_data, out_ready, ram_data_out,
        input  in_ready, out_valid, out_data, out_last,
               ram_wr_rd, ram_data_in, ram_wr_addr, ram_rd_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready, ram_data_out,
        output in_ready, out_valid, out_data, out_last,
               ram_wr_rd, ram_data_in, ram_wr_addr, ram_rd_addr
    );

endinterface

// File: rtl/idct_out_fifo2.sv
// 2-entry synchronous FIFO; head visible the cycle after push, no added latency on pop.
// Push while full is dropped unless a pop happens the same cycle; pop while empty is ignored.
module idct_out_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    output logic [1:0]   o_cnt
);

    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = i_pop && (r_cnt != 2'd0);
    assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_push_dat;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_vld = (r_cnt != 2'd0);
    assign o_dat = r_mem[r_rp];
    assign o_cnt = r_cnt;

endmodule

// File: rtl/idct_transpose_ctrl.sv
// Transpose-RAM controller: writes an 8x8 block row-major, streams it back column-major; first output 2 cycles after DRAIN entry, then 1/cycle.
// Back-pressure: in_ready low while draining; reads stall when the 2-entry buffer is full. Optional status ports: IDCT_TRANSPOSE_STATUS_EN.
module idct_transpose_ctrl
    import idct_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    idct_transpose_ctrl_if.slave  io_bus
`ifdef IDCT_TRANSPOSE_STATUS_EN
    ,
    output logic [15:0]           o_blk_cnt,
    output logic                  o_busy
`endif
);

    state_t        r_state;
    logic [AW-1:0] r_wr_cnt;
    logic [AW-1:0] r_rd_cnt;
    logic          r_rd_all;
    logic          r_inflight;
    logic          r_inflight_last;
    logic          r_in_rdy;

    logic          w_acc;
    logic          w_pop;
    logic          w_issue;
    logic          w_fifo_vld;
    logic          w_fifo_last;
    logic [DW-1:0] w_fifo_dat;
    logic [1:0]    w_fifo_cnt;

    assign w_acc = io_bus.in_valid && r_in_rdy;
    assign w_pop = w_fifo_vld && io_bus.out_ready;

    // Occupancy counts a same-cycle pop as freed space so a steady drain sustains one read per cycle.
    assign w_issue = (r_state == DRAIN) && !r_rd_all &&
                     (({1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= FILL;
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_rd_all        <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_in_rdy        <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_cnt == AW'(BLK - 1));
            case (r_state)
                FILL: begin
                    r_in_rdy <= 1'b1;
                    if (w_acc) begin
                        r_wr_cnt <= r_wr_cnt + AW'(1);
                        if (r_wr_cnt == AW'(BLK - 1)) begin
                            r_state  <= DRAIN;
                            r_in_rdy <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (w_issue) begin
                        r_rd_cnt <= r_rd_cnt + AW'(1);
                        if (r_rd_cnt == AW'(BLK - 1)) begin
                            r_rd_all <= 1'b1;
                        end
                    end
                    if (w_pop && w_fifo_last) begin
                        r_state  <= FILL;
                        r_rd_cnt <= '0;
                        r_rd_all <= 1'b0;
                        r_in_rdy <= 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // RAM data_out is valid the cycle after issue; the last flag travels alongside it.
    idct_out_fifo2 #(.W(DW + 1)) u_out_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_inflight),
        .i_push_dat ({r_inflight_last, io_bus.ram_data_out}),
        .i_pop      (w_pop),
        .o_vld      (w_fifo_vld),
        .o_dat      ({w_fifo_last, w_fifo_dat}),
        .o_cnt      (w_fifo_cnt)
    );

    assign io_bus.in_ready    = r_in_rdy;
    assign io_bus.ram_wr_rd   = w_acc;
    assign io_bus.ram_data_in = io_bus.in_data;
    assign io_bus.ram_wr_addr = r_wr_cnt;
    assign io_bus.ram_rd_addr = tr_addr(r_rd_cnt);
    assign io_bus.out_valid   = w_fifo_vld;
    assign io_bus.out_data    = w_fifo_dat;
    assign io_bus.out_last    = w_fifo_vld && w_fifo_last;

`ifdef IDCT_TRANSPOSE_STATUS_EN
    logic [15:0] r_blk_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (w_pop && w_fifo_last) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign o_blk_cnt = r_blk_cnt;
    assign o_busy    = (r_state == DRAIN) || (r_wr_cnt != '0);
`endif

endmodule

// File: tb/tb_idct_transpose_ctrl.sv
// Bench for idct_transpose_ctrl: RAM model, block-level transpose reference and a per-cycle compare process.
module tb_idct_transpose_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    idct_transpose_ctrl_if #(.DW(16)) bus ();

`ifdef IDCT_TRANSPOSE_STATUS_EN
    logic [15:0] blk_cnt;
    logic        busy;
`endif

    idct_transpose_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
`ifdef IDCT_TRANSPOSE_STATUS_EN
        ,
        .o_blk_cnt (blk_cnt),
        .o_busy    (busy)
`endif
    );

    // Transpose RAM with one-cycle registered read
    logic [15:0] mem [64];
    always @(posedge clk) begin
        if (bus.ram_wr_rd === 1'b1) mem[bus.ram_wr_addr] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_rd_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model state
    logic [15:0] part [64];
    int          part_n = 0;
    logic [16:0] exp_q [$];
    int          blk_done = 0;
    int          out_n = 0;
    int          acc_last_cyc = 0;
    int          first_acc_cyc = 0;
    int          first_vld_cyc = 0;
    int          last_hs_cyc = 0;
    bit          want_first = 0;
    bit          prev_rst = 1;

    always @(negedge clk) begin
        bit          exp_rdy;
        logic [16:0] e;
        if (rst) begin
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_in_ready", 32'(bus.in_ready), 0);
`ifdef IDCT_TRANSPOSE_STATUS_EN
            chk("rst_busy", 32'(busy), 0);
            chk("rst_blk_cnt", 32'(blk_cnt), 0);
`endif
            part_n = 0;
            exp_q.delete();
            blk_done = 0;
            out_n = 0;
            want_first = 0;
        end else begin
            exp_rdy = (exp_q.size() == 0) && !prev_rst;
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
`ifdef IDCT_TRANSPOSE_STATUS_EN
            chk("blk_cnt", 32'(blk_cnt), 32'(blk_done % 65536));
            chk("busy", 32'(busy), 32'((exp_q.size() != 0) || (part_n != 0)));
`endif
            // Output side
            if (exp_q.size() == 0) chk("idle_out_valid", 32'(bus.out_valid), 0);
            if (want_first && bus.out_valid) begin
                chk("first_latency", 32'(cyc - acc_last_cyc), 3);
                first_vld_cyc = cyc;
                want_first = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(bus.out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e[15:0]));
                    chk("out_last", 32'(bus.out_last), 32'(e[16]));
                    out_n++;
                    if (e[16]) begin
                        blk_done++;
                        last_hs_cyc = cyc;
                    end
                end
            end
            // Input / write side
            chk("ram_wr_rd", 32'(bus.ram_wr_rd), 32'(bus.in_valid && exp_rdy));
            if (bus.in_valid && exp_rdy) begin
                chk("ram_wr_addr", 32'(bus.ram_wr_addr), 32'(part_n));
                chk("ram_data_in", 32'(bus.ram_data_in), 32'(bus.in_data));
                if (part_n == 0) first_acc_cyc = cyc;
                part[part_n] = bus.in_data;
                part_n++;
                if (part_n == 64) begin
                    for (int k = 0; k < 64; k++)
                        exp_q.push_back({(k == 63), part[(k % 8) * 8 + k / 8]});
                    part_n = 0;
                    acc_last_cyc = cyc;
                    want_first = 1;
                end
            end
        end
        prev_rst = rst;
    end

    // out_ready pattern: 0 high, 1 toggle, 2 random, 3 held low
    int ord_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ord_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = !bus.out_ready;
            2:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // mode: 0 back-to-back, 1 every 3rd slot idle, 2 random valid, 3 random valid and data
    task automatic drive_block(input int base, input int mode);
        int i = 0;
        int slot = 0;
        bit v;
        bit acc;
        while (i < 64 && slot < 3000) begin
            v = (mode == 1) ? (slot % 3 != 2) : (mode >= 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = (mode == 3) ? 16'($urandom) : 16'(base + i);
            @(negedge clk);
            acc = v && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            slot++;
        end
        bus.in_valid = 1'b0;
        if (i < 64) chk("fill_timeout", 32'(i), 64);
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((exp_q.size() != 0 || part_n != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (n >= 3000) chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int base;
        int n;
        logic [5:0] a;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_wr_rd", 32'(bus.ram_wr_rd), 0);
        chk("rst_ram_wr_addr", 32'(bus.ram_wr_addr), 0);
        chk("rst_ram_rd_addr", 32'(bus.ram_rd_addr), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Ascending block, out_ready high
        ord_mode = 0;
        drive_block(0, 0);
        chk("model_size", 32'(exp_q.size()), 64);
        chk("model_k1", 32'(exp_q[1]), 32'(8));
        chk("model_k7", 32'(exp_q[7]), 32'(56));
        chk("model_k8", 32'(exp_q[8]), 32'(1));
        chk("model_k62", 32'(exp_q[62]), 32'(55));
        chk("model_k63", 32'(exp_q[63]), 32'(17'h1003F));
        wait_drained();
        chk("throughput", 32'(last_hs_cyc - first_vld_cyc), 63);
`ifdef IDCT_TRANSPOSE_STATUS_EN
        chk("busy_after_blk", 32'(busy), 0);
        chk("blk_cnt_1", 32'(blk_cnt), 1);
`endif

        // out_ready toggling
        ord_mode = 1;
        drive_block(0, 0);
        wait_drained();
`ifdef IDCT_TRANSPOSE_STATUS_EN
        chk("blk_cnt_2", 32'(blk_cnt), 2);
`endif

        // Input bubbles every third slot
        ord_mode = 0;
        drive_block(0, 1);
        wait_drained();

        // Two blocks back-to-back
        drive_block(0, 0);
        drive_block(100, 0);
        chk("b2b_in_ready_rise", 32'(first_acc_cyc - last_hs_cyc), 1);
        chk("b2b_model_k0", 32'(exp_q[0]), 32'(100));
        chk("b2b_model_k1", 32'(exp_q[1]), 32'(108));
        wait_drained();

        // Output stall: buffer fills, read address holds
        ord_mode = 3;
        drive_block(0, 3);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("stall_wait_valid", 32'(bus.out_valid), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = bus.ram_rd_addr;
        chk("stall_addr_value", 32'(a), 16);
        repeat (4) begin
            @(negedge clk);
            chk("rd_addr_stall", 32'(bus.ram_rd_addr), 32'(a));
            chk("stall_out_valid", 32'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1 ord_mode = 0;
        wait_drained();

        // Reset after 20 outputs of a block
        ord_mode = 0;
        base = out_n;
        drive_block(0, 3);
        n = 0;
        while (out_n < base + 20 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) chk("mid_rst_wait", 32'(out_n - base), 20);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        ord_mode = 2;
        drive_block(500, 0);
        wait_drained();
`ifdef IDCT_TRANSPOSE_STATUS_EN
        chk("blk_cnt_after_rst", 32'(blk_cnt), 1);
`endif

        // Randomised blocks
        for (int b = 0; b < 4; b++) begin
            ord_mode = 2;
            drive_block(b * 64, 2 + (b % 2));
            wait_drained();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
